// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between N_REQ draw stages: round-robin grant, tagged read-back.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr_clr ignored).
module sprite_rom_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 12,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                ptr_clr,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [DW-1:0]       rd_data
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [AW-1:0] gnt_addr;
  logic [N_REQ-1:0] rd_dec;
  tag_t          tag_q [0:ROM_LAT];

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  logic ptr_clr_unused;
  assign ptr_clr_unused = ptr_clr;

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(k);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] cand;
  int unsigned   sum;

  // Candidate index wraps explicitly so non-power-of-2 N_REQ never aliases.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    sum     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IW'(sum);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = gnt_idx + 1'b1;
    if (gnt_idx == IW'(N_REQ - 1)) ptr_nxt = '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ptr_clr) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= ptr_nxt;
    end
  end
`endif

  always_comb begin
    gnt_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IW'(k)) gnt_addr = addr_in[k*AW +: AW];
    end
  end

  always_comb begin
    rd_dec = '0;
    if (tag_q[ROM_LAT].vld) rd_dec[tag_q[ROM_LAT].idx] = 1'b1;
  end

  // Tag stage ROM_LAT lines up with rom_data; the output register adds the final cycle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      if (gnt_any) rom_addr <= gnt_addr;
      tag_q[0] <= '{vld: gnt_any, idx: gnt_idx};
      for (int unsigned k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
      rd_valid <= rd_dec;
      if (tag_q[ROM_LAT].vld) rd_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: one stimulus stream drives a ROM_LAT=1 and a ROM_LAT=3 instance.
module tb_sprite_rom_arbiter;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ptr_clr = 1'b0;
  logic [1:0]  req = '0;
  logic [23:0] addr_in = '0;
  logic [1:0]  gnt, gnt3, rd_valid, rd_valid3;
  logic [11:0] rom_addr, rom_addr3, rom_data, rom_data3, rd_data, rd_data3;

  always #5 pclk = ~pclk;

  sprite_rom_arbiter #(.N_REQ(2), .AW(12), .DW(12), .ROM_LAT(1)) dut (
    .pclk(pclk), .rst_n(rst_n), .ptr_clr(ptr_clr), .req(req), .addr_in(addr_in),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid(rd_valid), .rd_data(rd_data));

  sprite_rom_arbiter #(.N_REQ(2), .AW(12), .DW(12), .ROM_LAT(3)) dut_l3 (
    .pclk(pclk), .rst_n(rst_n), .ptr_clr(ptr_clr), .req(req), .addr_in(addr_in),
    .gnt(gnt3), .rom_addr(rom_addr3), .rom_data(rom_data3), .rd_valid(rd_valid3), .rd_data(rd_data3));

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return {a[3:0], a[11:4]} ^ 12'hA5A;
  endfunction

  logic [11:0] rom1;
  logic [11:0] r3 [3];
  always @(posedge pclk) begin
    rom1  <= rom_f(rom_addr);
    r3[0] <= rom_f(rom_addr3);
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign rom_data  = rom1;
  assign rom_data3 = r3[2];

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] d;
    int          due;
  } exp_t;
  exp_t sbq [2][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic [1:0] v, input logic [11:0] data);
    exp_t e;
    chk($sformatf("rd_valid_onehot%0d", d), 32'($onehot0(v)), 32'd1);
    if (v !== 2'b00) begin
      if (sbq[d].size() == 0) begin
        chk($sformatf("rd_valid_unexpected%0d", d), {30'd0, v}, 32'd0);
      end else begin
        e = sbq[d].pop_front();
        chk($sformatf("rd_owner%0d", d), {30'd0, v}, {30'd0, e.v});
        chk($sformatf("rd_data%0d", d), {20'd0, data}, {20'd0, e.d});
        chk($sformatf("rd_latency%0d", d), cyc, e.due);
      end
    end
  endtask

  always @(posedge pclk) begin
    #2;
    mon(0, rd_valid, rd_data);
    mon(1, rd_valid3, rd_data3);
  end

  typedef struct {
    bit          rst;
    bit          clr;
    logic [1:0]  rq;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [1:0]  eg;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit rst, input bit clr, input logic [1:0] rq,
                              input logic [11:0] a0, input logic [11:0] a1, input logic [1:0] eg);
    vec_t v;
    v.rst = rst; v.clr = clr; v.rq = rq; v.a0 = a0; v.a1 = a1; v.eg = eg;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int k = 0; k < n; k++) add(1, 0, 2'b00, 12'h000, 12'h000, 2'b00);
  endfunction

  initial begin
    logic [11:0] exp_ra;
    logic [11:0] ga;
    logic [1:0]  eg;
    exp_t        e;
    exp_ra = '0;

    for (int k = 0; k < 3; k++) add(0, 0, 2'b00, 12'h000, 12'h000, 2'b00);
    // single request released together with reset
    add(1, 0, 2'b01, 12'h040, 12'h000, 2'b01);
    idle(4);
    add(1, 1, 2'b00, 12'h000, 12'h000, 2'b00);
    // both requesting: strict alternation
    for (int k = 0; k < 6; k++)
      add(1, 0, 2'b11, 12'h100 + 12'(k), 12'h200 + 12'(k), k[0] ? 2'b10 : 2'b01);
    // lone requester 1 granted back to back
    for (int k = 0; k < 4; k++) add(1, 0, 2'b10, 12'h000, 12'h300 + 12'(k), 2'b10);
    idle(1);
    // ptr_clr overriding the post-grant update
    add(1, 0, 2'b01, 12'h400, 12'h000, 2'b01);
    add(1, 1, 2'b01, 12'h401, 12'h000, 2'b01);
    add(1, 0, 2'b11, 12'h402, 12'h502, 2'b01);
    add(1, 1, 2'b11, 12'h403, 12'h503, 2'b10);
    add(1, 0, 2'b11, 12'h404, 12'h504, 2'b01);
    idle(6);
    // reset with reads in flight
    add(1, 0, 2'b11, 12'h600, 12'h700, 2'b10);
    add(1, 0, 2'b11, 12'h601, 12'h701, 2'b01);
    add(0, 0, 2'b00, 12'h000, 12'h000, 2'b00);
    add(1, 0, 2'b11, 12'h620, 12'h720, 2'b01);
    idle(8);

    foreach (vecs[i]) begin
      @(negedge pclk);
      rst_n   = vecs[i].rst;
      ptr_clr = vecs[i].clr;
      req     = vecs[i].rq;
      addr_in = {vecs[i].a1, vecs[i].a0};
      if (!vecs[i].rst) begin
        sbq[0].delete();
        sbq[1].delete();
        exp_ra = '0;
      end
      #1;
      eg = vecs[i].eg;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      eg = vecs[i].rq & (~vecs[i].rq + 2'd1);
`endif
      chk("gnt", {30'd0, gnt}, {30'd0, eg});
      chk("gnt_l3", {30'd0, gnt3}, {30'd0, eg});
      chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rom_addr", {20'd0, rom_addr}, {20'd0, exp_ra});
      chk("rom_addr_l3", {20'd0, rom_addr3}, {20'd0, exp_ra});
      if (vecs[i].rst && eg != 2'b00) begin
        ga = eg[1] ? vecs[i].a1 : vecs[i].a0;
        e.v = eg; e.d = rom_f(ga);
        e.due = cyc + 3;
        sbq[0].push_back(e);
        e.due = cyc + 5;
        sbq[1].push_back(e);
        exp_ra = ga;
      end
    end

    @(negedge pclk);
    chk("sb_drained", 32'(sbq[0].size()), 32'd0);
    chk("sb_drained_l3", 32'(sbq[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
